reset_sequencer: RTL and testbench
==================================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of sequenced reset channels, legal range 1..32.
REQ-002 SHALL have parameter MIN_HOLD, default 8: cycles all channels are held in reset before the first release, legal range >=1.
REQ-003 SHALL have parameter STAGE_GAP, default 4: cycles between consecutive channel releases or assertions, legal range >=1.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port sw_rst_req, input, 1 bit: software reset request, level-sampled.
REQ-007 SHALL have port ch_rst_n, output, NUM_CH bits: per-channel active-low resets, registered.
REQ-008 SHALL have port ready, output, 1 bit: all channels released and sequence complete, registered.
REQ-009 SHALL have port busy, output, 1 bit: sequence in progress, equal to !ready.

Function
REQ-010 SHALL implement an FSM with states HOLD, RELEASE and RUN, plus SHUTDOWN when the macro in REQ-021 is defined.
REQ-011 SHALL number edges from 1, where edge 1 is the first rising edge that samples rst_n=1.
REQ-012 SHALL stay in HOLD with ch_rst_n all 0 until edge MIN_HOLD, then enter RELEASE.
REQ-013 SHALL drive ch_rst_n[i] to 1 after edge MIN_HOLD + i*STAGE_GAP, for i = 0..NUM_CH-1, in ascending order.
REQ-014 SHALL enter RUN and assert ready after edge MIN_HOLD + (NUM_CH-1)*STAGE_GAP + 1.
REQ-015 SHALL, for NUM_CH=1, release ch_rst_n[0] after edge MIN_HOLD and assert ready one edge later.
REQ-016 SHALL sample sw_rst_req only in RUN and ignore it in every other state.
REQ-017 SHALL deassert ready on the edge that accepts sw_rst_req.
REQ-018 SHALL size the gap and hold counters to $clog2(max(MIN_HOLD, STAGE_GAP)+1) bits, with no wrap-around before terminal count.
REQ-019 SHALL keep a held sw_rst_req from causing a re-trigger until the FSM is back in RUN, where it is sampled again.

Reset
REQ-020 SHALL, when rst_n=0 is sampled in any state (including mid-RELEASE or mid-SHUTDOWN), on that edge: ch_rst_n=0, ready=0, busy=1, state=HOLD, all counters and the channel index cleared.

Configuration
REQ-021 SHALL use macro RST_SEQ_REVERSE_ASSERT_EN: when defined, an accepted sw_rst_req enters SHUTDOWN. In SHUTDOWN:
- ch_rst_n[NUM_CH-1] goes to 0 on the accept edge.
- each lower channel goes to 0 STAGE_GAP edges after the previous one.
- the edge that drives ch_rst_n[0] to 0 also enters HOLD.
- from that edge, the sequence restarts per REQ-012..014, with edge numbering restarted there.
REQ-022 SHALL, when RST_SEQ_REVERSE_ASSERT_EN is undefined:
- an accepted sw_rst_req drives all ch_rst_n to 0 on the accept edge and enters HOLD.
- the sequence then restarts per REQ-012..014, with edge 1 being the next edge.
- no SHUTDOWN state or logic is present.

Verification
REQ-023 SHALL cover power-up with defaults: rst_n rises -> ch_rst_n[0..3] rise after edges 8/12/16/20, ready after edge 21.
REQ-024 SHALL cover reset mid-RELEASE: rst_n=0 at edge 14 -> ch_rst_n=4'b0000 and ready=0 after edge 14; on rst_n=1 the full sequence restarts.
REQ-025 SHALL cover a 1-cycle sw_rst_req in RUN, macro undefined: ch_rst_n=0 after the accept edge; re-release at +8/+12/+16/+20; ready at +21.
REQ-026 SHALL cover the same stimulus with the macro defined: ch3, ch2, ch1, ch0 low at +0/+4/+8/+12; HOLD entered at +12; re-release at +20/+24/+28/+32; ready at +33.
REQ-027 SHALL cover sw_rst_req held high during RELEASE: ignored, ready still asserts at the nominal edge; the held request then retriggers in RUN.
REQ-028 SHALL cover NUM_CH=1, MIN_HOLD=1, STAGE_GAP=1: ch_rst_n[0] rises after edge 1 and ready after edge 2.

Source files
------------

// File: rtl/reset_sequencer.sv
// reset_sequencer: staged release of NUM_CH active-low channel resets after a
// minimum hold time. Channels are released in ascending order, STAGE_GAP cycles
// apart, and ready/busy report when the whole sequence has completed.
// An accepted software reset request restarts the sequence.
// Build option RST_SEQ_REVERSE_ASSERT_EN: a software reset first asserts the
// channels in descending order, STAGE_GAP cycles apart, and only then restarts
// the release sequence. Without it all channels are asserted at once.
module reset_sequencer #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned MIN_HOLD  = 8,
  parameter int unsigned STAGE_GAP = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sw_rst_req,
  output logic [NUM_CH-1:0] ch_rst_n,
  output logic              ready,
  output logic              busy
);

  // One counter serves both the hold phase and the stage gaps.
  localparam int unsigned MAX_CNT = (MIN_HOLD > STAGE_GAP) ? MIN_HOLD : STAGE_GAP;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);
  localparam int unsigned IDX_W   = $clog2(NUM_CH + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MIN_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [IDX_W-1:0] IDX_ALL   = IDX_W'(NUM_CH);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

`ifdef RST_SEQ_REVERSE_ASSERT_EN
  typedef enum logic [1:0] {
    HOLD     = 2'd0,
    RELEASE  = 2'd1,
    RUN      = 2'd2,
    SHUTDOWN = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_t;
`endif

  state_t           state;
  logic [CNT_W-1:0] cnt;
  // RELEASE: index of the next channel to release.
  // SHUTDOWN: number of channels still released.
  logic [IDX_W-1:0] idx;

  // Sequencer FSM with registered channel resets, ready and busy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= HOLD;
      cnt      <= '0;
      idx      <= '0;
      ch_rst_n <= '0;
      ready    <= 1'b0;
      busy     <= 1'b1;
    end else begin
      case (state)
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt         <= '0;
            idx         <= IDX_ONE;
            ch_rst_n[0] <= 1'b1;
            state       <= RELEASE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        RELEASE: begin
          if (idx == IDX_ALL) begin
            cnt   <= '0;
            ready <= 1'b1;
            busy  <= 1'b0;
            state <= RUN;
          end else if (cnt == GAP_LAST) begin
            cnt <= '0;
            idx <= idx + IDX_W'(1);
            for (int unsigned i = 0; i < NUM_CH; i++) begin
              if (idx == IDX_W'(i)) begin
                ch_rst_n[i] <= 1'b1;
              end
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        RUN: begin
          if (sw_rst_req) begin
            cnt   <= '0;
            ready <= 1'b0;
            busy  <= 1'b1;
`ifdef RST_SEQ_REVERSE_ASSERT_EN
            ch_rst_n[NUM_CH-1] <= 1'b0;
            if (NUM_CH == 1) begin
              idx   <= '0;
              state <= HOLD;
            end else begin
              idx   <= IDX_W'(NUM_CH - 1);
              state <= SHUTDOWN;
            end
`else
            ch_rst_n <= '0;
            idx      <= '0;
            state    <= HOLD;
`endif
          end
        end

`ifdef RST_SEQ_REVERSE_ASSERT_EN
        SHUTDOWN: begin
          if (cnt == GAP_LAST) begin
            cnt <= '0;
            idx <= idx - IDX_W'(1);
            for (int unsigned i = 0; i < NUM_CH; i++) begin
              if (idx == IDX_W'(i + 1)) begin
                ch_rst_n[i] <= 1'b0;
              end
            end
            if (idx == IDX_ONE) begin
              state <= HOLD;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
`endif

        default: begin
          state    <= HOLD;
          cnt      <= '0;
          idx      <= '0;
          ch_rst_n <= '0;
          ready    <= 1'b0;
          busy     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: a default instance (4 channels, hold 8, gap 4) and
// a minimal instance (1 channel, hold 1, gap 1) share clock and rst_n.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sw_a;
  logic       sw_b;
  logic [3:0] ch_a;
  logic       rdy_a;
  logic       busy_a;
  logic [0:0] ch_b;
  logic       rdy_b;
  logic       busy_b;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  reset_sequencer #(.NUM_CH(4), .MIN_HOLD(8), .STAGE_GAP(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .sw_rst_req(sw_a),
    .ch_rst_n(ch_a), .ready(rdy_a), .busy(busy_a)
  );

  reset_sequencer #(.NUM_CH(1), .MIN_HOLD(1), .STAGE_GAP(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .sw_rst_req(sw_b),
    .ch_rst_n(ch_b), .ready(rdy_b), .busy(busy_b)
  );

  // ---------------- behavioural model ----------------
  // e: edges since the release sequence (re)started; s: edges since a
  // reverse shutdown started.
  int e[2];
  int s[2];
  bit shut[2];

  function automatic int pn(input int k); return (k == 0) ? 4 : 1; endfunction
  function automatic int pm(input int k); return (k == 0) ? 8 : 1; endfunction
  function automatic int pg(input int k); return (k == 0) ? 4 : 1; endfunction
  function automatic int pt(input int k); return pm(k) + (pn(k) - 1) * pg(k) + 1; endfunction

  task automatic model_step(input int k, input logic r, input logic sw);
    if (!r) begin
      e[k] = 0; s[k] = 0; shut[k] = 1'b0;
    end else if (shut[k]) begin
      s[k] = s[k] + 1;
      if (s[k] >= (pn(k) - 1) * pg(k)) begin
        shut[k] = 1'b0; e[k] = 0;
      end
    end else if (e[k] >= pt(k) && sw) begin
`ifdef RST_SEQ_REVERSE_ASSERT_EN
      s[k] = 0;
      if (pn(k) == 1) e[k] = 0;
      else shut[k] = 1'b1;
`else
      e[k] = 0;
`endif
    end else if (e[k] < pt(k)) begin
      e[k] = e[k] + 1;
    end
  endtask

  function automatic logic [31:0] exp_ch(input int k);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < pn(k); i++) begin
      if (shut[k]) v[i] = !(s[k] >= (pn(k) - 1 - i) * pg(k));
      else         v[i] = (e[k] >= pm(k) + i * pg(k));
    end
    return v;
  endfunction

  function automatic logic exp_rdy(input int k);
    return !shut[k] && (e[k] >= pt(k));
  endfunction

  initial begin
    for (int k = 0; k < 2; k++) begin
      e[k] = 0; s[k] = 0; shut[k] = 1'b0;
    end
  end

  // Advance the model on every active edge from the inputs it sampled.
  always @(posedge clk) begin
    model_step(0, rst_n, sw_a);
    model_step(1, rst_n, sw_b);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks = checks + 1;
    if (act !== req) begin
      failures = failures + 1;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, req);
    end
  endtask

  // Compare both instances against the model every cycle after reset.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("model_a_ch",   32'(ch_a),   exp_ch(0));
      check("model_a_rdy",  32'(rdy_a),  32'(exp_rdy(0)));
      check("model_a_busy", 32'(busy_a), 32'(!exp_rdy(0)));
      check("model_b_ch",   32'(ch_b),   exp_ch(1));
      check("model_b_rdy",  32'(rdy_b),  32'(exp_rdy(1)));
      check("model_b_busy", 32'(busy_b), 32'(!exp_rdy(1)));
    end
  end

  // ---------------- hand-computed expectations ----------------
  task automatic lit_a(input int k);
    logic [3:0] c;
    logic       r;
    bit         en;
    en = 1'b1; c = 4'b0000; r = 1'b0;
    case (k)
      7:  c = 4'b0000;
      8:  c = 4'b0001;
      11: c = 4'b0001;
      12: c = 4'b0011;
      16: c = 4'b0111;
      19: c = 4'b0111;
      20: c = 4'b1111;
      21: begin c = 4'b1111; r = 1'b1; end
      default: en = 1'b0;
    endcase
    if (en) begin
      check($sformatf("lit_a_ch_e%0d", k),  32'(ch_a),  32'(c));
      check($sformatf("lit_a_rdy_e%0d", k), 32'(rdy_a), 32'(r));
    end
  endtask

  task automatic lit_b(input int k);
    if (k == 1) begin
      check("lit_b_ch_e1",  32'(ch_b),  32'd1);
      check("lit_b_rdy_e1", 32'(rdy_b), 32'd0);
    end else if (k == 2) begin
      check("lit_b_rdy_e2", 32'(rdy_b), 32'd1);
    end
  endtask

  // j = edges after the edge that accepted a one-cycle software request.
  task automatic lit_sw(input int j);
    logic [3:0] c;
    logic       r;
    bit         en;
    en = 1'b1; c = 4'b0000; r = 1'b0;
`ifdef RST_SEQ_REVERSE_ASSERT_EN
    case (j)
      0:  c = 4'b0111;
      4:  c = 4'b0011;
      8:  c = 4'b0001;
      11: c = 4'b0001;
      12: c = 4'b0000;
      19: c = 4'b0000;
      20: c = 4'b0001;
      32: c = 4'b1111;
      33: begin c = 4'b1111; r = 1'b1; end
      default: en = 1'b0;
    endcase
`else
    case (j)
      0:  c = 4'b0000;
      7:  c = 4'b0000;
      8:  c = 4'b0001;
      12: c = 4'b0011;
      20: c = 4'b1111;
      21: begin c = 4'b1111; r = 1'b1; end
      default: en = 1'b0;
    endcase
`endif
    if (en) begin
      check($sformatf("lit_sw_ch_p%0d", j),  32'(ch_a),  32'(c));
      check($sformatf("lit_sw_rdy_p%0d", j), 32'(rdy_a), 32'(r));
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst_n = 1'b0; sw_a = 1'b0; sw_b = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("reset_ch_a",   32'(ch_a),   32'd0);
    check("reset_rdy_a",  32'(rdy_a),  32'd0);
    check("reset_busy_a", 32'(busy_a), 32'd1);
    check("reset_ch_b",   32'(ch_b),   32'd0);

    // Power-up sequence with defaults.
    rst_n = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      @(posedge clk); #1;
      lit_a(k);
      lit_b(k);
    end

    // One-cycle software request in RUN.
    @(negedge clk);
    sw_a = 1'b1; sw_b = 1'b1;
    @(posedge clk); #1;
    lit_sw(0);
    check("lit_sw_b_ch_p0", 32'(ch_b), 32'd0);
    @(negedge clk);
    sw_a = 1'b0; sw_b = 1'b0;
    for (int j = 1; j <= 36; j++) begin
      @(posedge clk); #1;
      lit_sw(j);
    end

    // Reset sampled mid-RELEASE at edge 14, then a full restart.
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (13) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrel_ch_a",   32'(ch_a),   32'd0);
    check("midrel_rdy_a",  32'(rdy_a),  32'd0);
    check("midrel_busy_a", 32'(busy_a), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      @(posedge clk); #1;
      lit_a(k);
      lit_b(k);
    end

    // Software request held high from inside RELEASE.
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk); sw_a = 1'b1;
    for (int k = 11; k <= 22; k++) begin
      @(posedge clk); #1;
      if (k == 20) check("held_rdy_e20", 32'(rdy_a), 32'd0);
      if (k == 21) check("held_rdy_e21", 32'(rdy_a), 32'd1);
      if (k == 22) check("held_rdy_e22", 32'(rdy_a), 32'd0);
    end
    repeat (70) @(posedge clk);
    @(negedge clk); sw_a = 1'b0;
    repeat (50) @(posedge clk);
    #2;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
